multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
Multi-cycle MIPS control unit that sequences the datapath: PC, IR, register file, ALU, data memory and the 16→32 immediate extender. It decodes the IR opcode/funct and, per state, drives the write enables, the mux selects and the extender mode `Extop` (1 = sign, 0 = zero). It sits between the IR and the datapath, one instruction at a time, with no pipelining.

Parameters:
- ILLEGAL_HALT, 0, 1 = an unknown opcode/funct enters S_HALT permanently; 0 = it is treated as a NOP and returns to S_FETCH.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  IR[31:26], stable from the cycle after S_FETCH
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag, valid in S_EXE
- PCWr  out  1  PC write enable
- IRWr  out  1  IR write enable
- RegWr  out  1  register-file write enable
- MemWr  out  1  data-memory write enable
- Extop  out  1  extender mode: 1 = sign, 0 = zero
- ALUSrc  out  1  0 = rt, 1 = extended immediate
- ALUOp  out  3  000 ADDU, 001 SUBU, 010 OR, 011 LUI
- RegDst  out  2  00 rt, 01 rd, 10 $31
- MemtoReg  out  2  00 ALU, 01 mem, 10 PC (already PC+4)
- NPCOp  out  2  00 PC+4, 01 branch, 10 jump, 11 jr
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- state  out  3  current state, for debug

Behaviour:
- The state register updates on rising clk. While reset=1: state←S_FETCH next edge, and all write enables (PCWr, IRWr, RegWr, MemWr) and instr_done are forced 0 combinationally. All other outputs are 0 during reset.
- Reset asserted mid-instruction aborts it. No write enable fires in that cycle.
- Outputs are combinational from state, opcode, funct and zero. Outputs not listed for a state are 0.
- Supported instructions: addu (R, funct 100001), subu (R, 100011), jr (R, 001000), ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- States: S_FETCH=0, S_DECODE=1, S_EXE=2, S_MEM=3, S_WB=4, S_HALT=5.
- S_FETCH: IRWr=1, PCWr=1, NPCOp=00 → S_DECODE.
- S_DECODE:
  - j: PCWr, NPCOp=10.
  - jal: PCWr, NPCOp=10, RegWr, RegDst=10, MemtoReg=10.
  - jr: PCWr, NPCOp=11.
  - j/jal/jr assert instr_done → S_FETCH.
  - Illegal opcode/funct: instr_done → S_FETCH, or S_HALT if ILLEGAL_HALT=1.
  - Anything else → S_EXE.
- S_EXE:
  - addu/subu: ALUSrc=0, ALUOp ADDU/SUBU → S_WB.
  - ori: ALUSrc=1, Extop=0, ALUOp=OR → S_WB.
  - lui: ALUSrc=1, Extop=0, ALUOp=LUI → S_WB.
  - lw/sw: ALUSrc=1, Extop=1, ALUOp=ADDU → S_MEM.
  - beq: ALUSrc=0, ALUOp=SUBU, Extop=1, NPCOp=01, PCWr=zero, instr_done → S_FETCH.
- S_MEM: address operands are held (ALUSrc=1, Extop=1).
  - sw: MemWr=1, instr_done → S_FETCH.
  - lw → S_WB.
- S_WB: RegWr=1, instr_done → S_FETCH.
  - R-type: RegDst=01, MemtoReg=00.
  - ori/lui: RegDst=00, MemtoReg=00.
  - lw: RegDst=00, MemtoReg=01.
- S_HALT: all enables 0, held until reset.
- Cycle counts: j/jal/jr 2; beq 3; sw 4; R-type/ori/lui 4; lw 5.
- Extop, ALUSrc and ALUOp are held constant across S_EXE→S_MEM→S_WB for one instruction, so registered datapath values stay consistent.
- An unreachable state encoding (6, 7) → S_FETCH next cycle, all enables 0.

Decomposition:
- Package `mips_defs`: opcode/funct constants, the ALUOp, RegDst, MemtoReg and NPCOp encodings, and the state encodings.
- Sub-module `ctrl_decode`: combinational opcode/funct → one-hot instruction class (is_r_alu, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal, is_jr, is_illegal). The FSM consumes only this class vector.

Test Plan:
- Reset for 2 cycles, then release → state=0, IRWr=PCWr=1 in the first cycle, no RegWr/MemWr during reset.
- lw (opcode 100011) → states 0,1,2,3,4. In S_EXE: Extop=1, ALUSrc=1, ALUOp=000. In S_WB: RegWr=1, MemtoReg=01. instr_done only in cycle 5.
- ori (001101) → Extop=0, ALUOp=010 in S_EXE. RegWr=1, RegDst=00 in S_WB. 4 cycles.
- beq with zero=1, then with zero=0 → PCWr=1/NPCOp=01 resp. PCWr=0 in S_EXE. 3 cycles each.
- jal → 2 cycles. In S_DECODE: PCWr=1, NPCOp=10, RegWr=1, RegDst=10, MemtoReg=10. Then jr (funct 001000) → NPCOp=11.
- Illegal opcode 111111 with ILLEGAL_HALT=0 → back to S_FETCH, no writes. With ILLEGAL_HALT=1 → state=5, held. Reset asserted in S_MEM of sw → MemWr=0, then S_FETCH.

Source files
------------

// File: rtl/mips_defs_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs,
// datapath select codes, FSM states and the decoded instruction class.
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] ALU_ADDU = 3'b000;
    localparam logic [2:0] ALU_SUBU = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_LUI  = 3'b011;

    localparam logic [1:0] RD_RT    = 2'b00;
    localparam logic [1:0] RD_RD    = 2'b01;
    localparam logic [1:0] RD_RA    = 2'b10;

    localparam logic [1:0] M2R_ALU  = 2'b00;
    localparam logic [1:0] M2R_MEM  = 2'b01;
    localparam logic [1:0] M2R_PC   = 2'b10;

    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_JMP  = 2'b10;
    localparam logic [1:0] NPC_JR   = 2'b11;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // One-hot class; r_sub only qualifies is_r_alu (addu vs subu).
    typedef struct packed {
        logic is_r_alu;
        logic is_ori;
        logic is_lui;
        logic is_lw;
        logic is_sw;
        logic is_beq;
        logic is_j;
        logic is_jal;
        logic is_jr;
        logic is_illegal;
        logic r_sub;
    } ins_class_t;

    typedef struct packed {
        logic       extop;
        logic       alusrc;
        logic [2:0] aluop;
    } alu_ctrl_t;

    // ALU operand controls are a pure function of the class so that the
    // same values are presented in S_EXE, S_MEM and S_WB.
    function automatic alu_ctrl_t alu_ctrl(input ins_class_t cls);
        alu_ctrl_t c;
        c = '0;
        if (cls.is_r_alu) begin
            c.aluop = cls.r_sub ? ALU_SUBU : ALU_ADDU;
        end else if (cls.is_ori) begin
            c.alusrc = 1'b1;
            c.aluop  = ALU_OR;
        end else if (cls.is_lui) begin
            c.alusrc = 1'b1;
            c.aluop  = ALU_LUI;
        end else if (cls.is_lw || cls.is_sw) begin
            c.extop  = 1'b1;
            c.alusrc = 1'b1;
            c.aluop  = ALU_ADDU;
        end else if (cls.is_beq) begin
            c.extop  = 1'b1;
            c.aluop  = ALU_SUBU;
        end
        return c;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct decoder producing the one-hot instruction class.
module ctrl_decode
    import mips_defs::*;
(
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    output ins_class_t  cls
);

    always_comb begin
        cls = '0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: cls.is_r_alu = 1'b1;
                    FN_SUBU: begin
                        cls.is_r_alu = 1'b1;
                        cls.r_sub    = 1'b1;
                    end
                    FN_JR:   cls.is_jr = 1'b1;
                    default: cls.is_illegal = 1'b1;
                endcase
            end
            OP_ORI:  cls.is_ori = 1'b1;
            OP_LUI:  cls.is_lui = 1'b1;
            OP_LW:   cls.is_lw  = 1'b1;
            OP_SW:   cls.is_sw  = 1'b1;
            OP_BEQ:  cls.is_beq = 1'b1;
            OP_J:    cls.is_j   = 1'b1;
            OP_JAL:  cls.is_jal = 1'b1;
            default: cls.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/
// writeback and drives datapath enables and selects from the decoded class.
module multicycle_ctrl
    import mips_defs::*;
#(
    parameter bit ILLEGAL_HALT = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       PCWr,
    output logic       IRWr,
    output logic       RegWr,
    output logic       MemWr,
    output logic       Extop,
    output logic       ALUSrc,
    output logic [2:0] ALUOp,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic [1:0] NPCOp,
    output logic       instr_done,
    output logic [2:0] state
);

    state_t     state_q, state_d;
    ins_class_t cls;
    alu_ctrl_t  alu;

    ctrl_decode u_decode (
        .opcode (opcode),
        .funct  (funct),
        .cls    (cls)
    );

    assign alu   = alu_ctrl(cls);
    assign state = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        PCWr       = 1'b0;
        IRWr       = 1'b0;
        RegWr      = 1'b0;
        MemWr      = 1'b0;
        Extop      = 1'b0;
        ALUSrc     = 1'b0;
        ALUOp      = ALU_ADDU;
        RegDst     = RD_RT;
        MemtoReg   = M2R_ALU;
        NPCOp      = NPC_PC4;
        instr_done = 1'b0;

        case (state_q)
            S_FETCH: begin
                IRWr    = 1'b1;
                PCWr    = 1'b1;
                NPCOp   = NPC_PC4;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (cls.is_j || cls.is_jal) begin
                    PCWr       = 1'b1;
                    NPCOp      = NPC_JMP;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                    if (cls.is_jal) begin
                        RegWr    = 1'b1;
                        RegDst   = RD_RA;
                        MemtoReg = M2R_PC;
                    end
                end else if (cls.is_jr) begin
                    PCWr       = 1'b1;
                    NPCOp      = NPC_JR;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else if (cls.is_illegal) begin
                    instr_done = 1'b1;
                    state_d    = ILLEGAL_HALT ? S_HALT : S_FETCH;
                end else begin
                    state_d = S_EXE;
                end
            end
            S_EXE: begin
                Extop  = alu.extop;
                ALUSrc = alu.alusrc;
                ALUOp  = alu.aluop;
                if (cls.is_beq) begin
                    PCWr       = zero;
                    NPCOp      = NPC_BR;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else if (cls.is_lw || cls.is_sw) begin
                    state_d = S_MEM;
                end else if (cls.is_r_alu || cls.is_ori || cls.is_lui) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                Extop  = alu.extop;
                ALUSrc = alu.alusrc;
                ALUOp  = alu.aluop;
                if (cls.is_sw) begin
                    MemWr      = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else if (cls.is_lw) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_WB: begin
                Extop      = alu.extop;
                ALUSrc     = alu.alusrc;
                ALUOp      = alu.aluop;
                RegWr      = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
                if (cls.is_r_alu) begin
                    RegDst = RD_RD;
                end else if (cls.is_lw) begin
                    MemtoReg = M2R_MEM;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset suppresses every output so an aborted instruction writes nothing.
        if (reset) begin
            PCWr       = 1'b0;
            IRWr       = 1'b0;
            RegWr      = 1'b0;
            MemWr      = 1'b0;
            Extop      = 1'b0;
            ALUSrc     = 1'b0;
            ALUOp      = ALU_ADDU;
            RegDst     = RD_RT;
            MemtoReg   = M2R_ALU;
            NPCOp      = NPC_PC4;
            instr_done = 1'b0;
        end
    end

endmodule
